// File: rtl/hazard_fwd_ctrl_if.sv
// Bundle of ID-stage source operands, pipeline destinations, MDU events and
// the forwarding/stall results exchanged with hazard_fwd_ctrl.
interface hazard_fwd_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5
);
  logic [NUM_SRC*REG_AW-1:0] id_rs_addr_i;
  logic [NUM_SRC-1:0]        id_rs_en_i;
  logic [REG_AW-1:0]         ex_rd_addr_i;
  logic                      ex_rd_en_i;
  logic                      ex_is_load_i;
  logic [REG_AW-1:0]         mem_rd_addr_i;
  logic                      mem_rd_en_i;
  logic [REG_AW-1:0]         wb_rd_addr_i;
  logic                      wb_rd_en_i;
  // mdu_issue_i / mdu_done_i are single-cycle strobes with no ready: each
  // cycle they are high counts as exactly one event, and there is no backpressure.
  logic                      mdu_issue_i;
  logic [REG_AW-1:0]         mdu_issue_rd_i;
  logic                      mdu_done_i;
  logic [REG_AW-1:0]         mdu_done_rd_i;
  logic                      flush_i;
  logic [NUM_SRC*2-1:0]      fwd_sel_o;
  logic                      stall_o;
  logic                      bubble_o;
  logic                      mdu_full_o;
  logic [1:0]                dbg_state_o;

  modport master (
    output id_rs_addr_i, id_rs_en_i, ex_rd_addr_i, ex_rd_en_i, ex_is_load_i,
           mem_rd_addr_i, mem_rd_en_i, wb_rd_addr_i, wb_rd_en_i,
           mdu_issue_i, mdu_issue_rd_i, mdu_done_i, mdu_done_rd_i, flush_i,
    input  fwd_sel_o, stall_o, bubble_o, mdu_full_o, dbg_state_o
  );

  modport slave (
    input  id_rs_addr_i, id_rs_en_i, ex_rd_addr_i, ex_rd_en_i, ex_is_load_i,
           mem_rd_addr_i, mem_rd_en_i, wb_rd_addr_i, wb_rd_en_i,
           mdu_issue_i, mdu_issue_rd_i, mdu_done_i, mdu_done_rd_i, flush_i,
    output fwd_sel_o, stall_o, bubble_o, mdu_full_o, dbg_state_o
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding select, load-use bubble and MDU scoreboard stall control.
// Optional macro HAZARD_WB_BYPASS_EN: WB matches and MDU done-cycle results bypass as sel 10.
module hazard_fwd_ctrl #(
  parameter int NUM_SRC   = 2,
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int MDU_DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  hazard_fwd_ctrl_if.slave bus
);
  localparam int NREG = 1 << REG_AW;
  localparam int CW   = $clog2(MDU_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MDU_DEPTH);
  localparam logic [2:0]    LU_INIT = 3'(LOAD_LAT - 1);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b11;
`ifdef HAZARD_WB_BYPASS_EN
  localparam logic [1:0] SEL_WB  = 2'b10;
`else
  localparam logic [1:0] SEL_WB  = SEL_RF;
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LU_WAIT = 2'd1;
  localparam logic [1:0] S_SB_WAIT = 2'd2;

  logic [1:0]      r_state;
  logic [2:0]      r_ctr;
  logic [NREG-1:0] r_pending;
  logic [CW-1:0]   r_cnt;
  logic            r_full;

  logic [1:0]      w_state_nxt;
  logic [2:0]      w_ctr_nxt;
  logic [NREG-1:0] w_pend_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_stall;
  logic            w_load_use;
  logic            w_sb_haz;
  logic [NUM_SRC*2-1:0] w_fwd_sel;

  logic [REG_AW-1:0] w_src_addr [NUM_SRC];
  logic [NUM_SRC-1:0] w_src_v;
  logic w_ex_v, w_mem_v, w_wb_v, w_issue_v, w_done_v;

  assign w_ex_v    = bus.ex_rd_en_i  && (bus.ex_rd_addr_i  != '0);
  assign w_mem_v   = bus.mem_rd_en_i && (bus.mem_rd_addr_i != '0);
  assign w_wb_v    = bus.wb_rd_en_i  && (bus.wb_rd_addr_i  != '0);
  // x0 never has an outstanding MDU op, so neither strobe counts for it.
  assign w_issue_v = bus.mdu_issue_i && (bus.mdu_issue_rd_i != '0);
  assign w_done_v  = bus.mdu_done_i  && (bus.mdu_done_rd_i  != '0);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_src_addr[g] = bus.id_rs_addr_i[g*REG_AW +: REG_AW];
    assign w_src_v[g]    = bus.id_rs_en_i[g] && (w_src_addr[g] != '0);
  end

  always_comb begin
    w_fwd_sel  = '0;
    w_load_use = 1'b0;
    w_sb_haz   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_src_v[k]) begin
        if (w_ex_v && (w_src_addr[k] == bus.ex_rd_addr_i))
          w_fwd_sel[k*2 +: 2] = SEL_EX;
        else if (w_mem_v && (w_src_addr[k] == bus.mem_rd_addr_i))
          w_fwd_sel[k*2 +: 2] = SEL_MEM;
        else if (w_wb_v && (w_src_addr[k] == bus.wb_rd_addr_i))
          w_fwd_sel[k*2 +: 2] = SEL_WB;
        else if (w_done_v && (w_src_addr[k] == bus.mdu_done_rd_i))
          w_fwd_sel[k*2 +: 2] = SEL_WB;
        if (w_ex_v && bus.ex_is_load_i && (w_src_addr[k] == bus.ex_rd_addr_i))
          w_load_use = 1'b1;
        if (r_pending[w_src_addr[k]] &&
            !(w_done_v && (w_src_addr[k] == bus.mdu_done_rd_i)))
          w_sb_haz = 1'b1;
      end
    end
  end

  // SB_WAIT re-evaluates hazards exactly like IDLE so stall drops in the clearing cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ctr_nxt   = r_ctr;
    w_stall     = 1'b0;
    if (bus.flush_i) begin
      w_state_nxt = S_IDLE;
      w_ctr_nxt   = '0;
    end else begin
      case (r_state)
        S_LU_WAIT: begin
          w_stall   = 1'b1;
          w_ctr_nxt = r_ctr - 3'd1;
          if (r_ctr <= 3'd1) begin
            w_state_nxt = S_IDLE;
            w_ctr_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          if (w_load_use) begin
            w_stall = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt = S_LU_WAIT;
              w_ctr_nxt   = LU_INIT;
            end
          end else if (w_sb_haz) begin
            w_stall     = 1'b1;
            w_state_nxt = S_SB_WAIT;
          end
        end
      endcase
    end
  end

  // Set is applied after clear so a same-cycle issue/done of one rd stays pending.
  always_comb begin
    w_pend_nxt = r_pending;
    w_cnt_nxt  = r_cnt;
    if (w_done_v)  w_pend_nxt[bus.mdu_done_rd_i]  = 1'b0;
    if (w_issue_v) w_pend_nxt[bus.mdu_issue_rd_i] = 1'b1;
    case ({w_issue_v, w_done_v})
      2'b10:   if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   if (r_cnt != '0)      w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ctr     <= '0;
      r_pending <= '0;
      r_cnt     <= '0;
      r_full    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ctr     <= w_ctr_nxt;
      r_pending <= w_pend_nxt;
      r_cnt     <= w_cnt_nxt;
      r_full    <= (w_cnt_nxt == CNT_MAX);
    end
  end

  assign bus.fwd_sel_o   = w_fwd_sel;
  assign bus.stall_o     = w_stall;
  assign bus.bubble_o    = w_stall;
  assign bus.mdu_full_o  = r_full;
  assign bus.dbg_state_o = r_state;
endmodule
